// File: rtl/hazard_pkg.sv
// Shared types and constants for the branch/load-use hazard controller.
package hazard_pkg;

    localparam int unsigned SHADOW_MAX = 7;
    localparam int unsigned SHADOW_W   = 3;
    localparam int unsigned REG_W      = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // Load-use: EX load writes a register the ID instruction reads ($zero never hazards).
    function automatic logic load_use(input logic             mem_read,
                                      input logic [REG_W-1:0] rt_ex,
                                      input logic [REG_W-1:0] rs_id,
                                      input logic [REG_W-1:0] rt_id);
        return mem_read && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module hazard_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch-flush and load-use stall controller with optional statistics counters.
// Statistics are built only when BRANCH_HAZARD_STATS_EN is defined.
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned SHADOW = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Branch,
    input  logic             Zero,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] Rt_EX,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    output logic             PCSrc,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e              r_state;
    state_e              w_state_next;
    logic [SHADOW_W-1:0] r_shadow;
    logic [SHADOW_W-1:0] w_shadow_next;
    logic                w_taken;
    logic                w_hazard;

    assign w_taken  = Branch & Zero;
    assign w_hazard = load_use(MemRead_EX, Rt_EX, Rs_ID, Rt_ID);

    always_comb begin
        w_state_next  = r_state;
        w_shadow_next = r_shadow;
        PCSrc         = 1'b0;
        PCWrite       = 1'b1;
        IFID_Write    = 1'b1;
        IFID_Flush    = 1'b0;
        IDEX_Flush    = 1'b0;
        EXMEM_Flush   = 1'b0;

        case (r_state)
            ST_FLUSH: begin
                w_shadow_next = r_shadow - SHADOW_W'(1);
                if (r_shadow <= SHADOW_W'(1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                // Taken wins over a stall; LDSTALL masks the hazard it already handled.
                if (w_taken) begin
                    PCSrc         = 1'b1;
                    IFID_Flush    = 1'b1;
                    IDEX_Flush    = 1'b1;
                    EXMEM_Flush   = 1'b1;
                    w_state_next  = ST_FLUSH;
                    w_shadow_next = SHADOW_W'(SHADOW);
                end else if (w_hazard && (r_state == ST_RUN)) begin
                    PCWrite      = 1'b0;
                    IFID_Write   = 1'b0;
                    IDEX_Flush   = 1'b1;
                    w_state_next = ST_LDSTALL;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase

        // Outputs are held inactive for as long as reset is asserted.
        if (rst) begin
            PCSrc       = 1'b0;
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b0;
            IDEX_Flush  = 1'b0;
            EXMEM_Flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_next;
            r_shadow <= w_shadow_next;
        end
    end

`ifdef BRANCH_HAZARD_STATS_EN
    logic w_eval;
    logic w_br_inc;
    logic w_taken_inc;
    logic w_stall_inc;

    assign w_eval      = (r_state != ST_FLUSH);
    assign w_br_inc    = w_eval & Branch;
    assign w_taken_inc = w_eval & w_taken;
    assign w_stall_inc = (r_state == ST_RUN) & w_hazard & ~w_taken;

    hazard_sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_br_inc),
        .count (br_cnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_taken_inc),
        .count (taken_cnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );
`else
    assign br_cnt    = '0;
    assign taken_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl (SHADOW=2, CNT_W=4).
module tb_branch_hazard_ctrl;

    localparam logic [5:0] IDLE = 6'b011000;
    localparam logic [5:0] TKN  = 6'b111111;
    localparam logic [5:0] STL  = 6'b000010;
    localparam logic [5:0] ZRO  = 6'b000000;

    // Control vector {rst, Branch, Zero, MemRead_EX}
    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_TAKEN = 4'b0110;
    localparam logic [3:0] C_RST   = 4'b1000;
    localparam logic [3:0] C_LOAD  = 4'b0001;
    localparam logic [3:0] C_BOTH  = 4'b0111;

    typedef struct {
        string      name;
        logic [5:0] outs;
        logic [3:0] br;
        logic [3:0] tk;
        logic [3:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Branch = 1'b0;
    logic       Zero = 1'b0;
    logic       MemRead_EX = 1'b0;
    logic [4:0] Rt_EX = '0;
    logic [4:0] Rs_ID = '0;
    logic [4:0] Rt_ID = '0;
    logic       PCSrc, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush;
    logic [3:0] br_cnt, taken_cnt, stall_cnt;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_hazard_ctrl #(.SHADOW(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .Branch      (Branch),
        .Zero        (Zero),
        .MemRead_EX  (MemRead_EX),
        .Rt_EX       (Rt_EX),
        .Rs_ID       (Rs_ID),
        .Rt_ID       (Rt_ID),
        .PCSrc       (PCSrc),
        .PCWrite     (PCWrite),
        .IFID_Write  (IFID_Write),
        .IFID_Flush  (IFID_Flush),
        .IDEX_Flush  (IDEX_Flush),
        .EXMEM_Flush (EXMEM_Flush),
        .br_cnt      (br_cnt),
        .taken_cnt   (taken_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Expected counter value: saturates at 15, or always 0 when stats are not built.
    function automatic logic [3:0] cv(input int v);
`ifdef BRANCH_HAZARD_STATS_EN
        return (v > 15) ? 4'd15 : 4'(v);
`else
        return (v < 0) ? 4'd1 : 4'd0;
`endif
    endfunction

    task automatic cyc(input string name, input logic [3:0] ctl, input logic [14:0] regs,
                       input logic [5:0] outs, input int br, input int tk, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, Branch, Zero, MemRead_EX} = ctl;
        {Rt_EX, Rs_ID, Rt_ID}           = regs;
        e.name = name;
        e.outs = outs;
        e.br   = cv(br);
        e.tk   = cv(tk);
        e.st   = cv(st);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_checks++;
            if ({PCSrc, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush} != m_e.outs) begin
                n_errors++;
                $display("FAIL %s outputs: got %b expected %b", m_e.name,
                         {PCSrc, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush},
                         m_e.outs);
            end
            n_checks++;
            if ({br_cnt, taken_cnt, stall_cnt} != {m_e.br, m_e.tk, m_e.st}) begin
                n_errors++;
                $display("FAIL %s counters: got br=%0d taken=%0d stall=%0d expected %0d/%0d/%0d",
                         m_e.name, br_cnt, taken_cnt, stall_cnt, m_e.br, m_e.tk, m_e.st);
            end
        end
    end

    initial begin
        cyc("reset", C_RST, 15'd0, ZRO, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc("idle", C_IDLE, 15'd0, IDLE, 0, 0, 0);

        // Taken branch and its shadow.
        cyc("taken_T",   C_TAKEN, 15'd0, TKN,  0, 0, 0);
        cyc("shadow_T1", C_TAKEN, 15'd0, IDLE, 1, 1, 0);
        cyc("shadow_T2", C_TAKEN, 15'd0, IDLE, 1, 1, 0);
        cyc("taken_T3",  C_TAKEN, 15'd0, TKN,  1, 1, 0);
        cyc("flush_a",   C_IDLE,  15'd0, IDLE, 2, 2, 0);
        cyc("flush_b",   C_IDLE,  15'd0, IDLE, 2, 2, 0);
        cyc("run_after", C_IDLE,  15'd0, IDLE, 2, 2, 0);

        // Load-use on Rs, then the Rt_EX==0 exclusion, then Rt match.
        cyc("ldstall",   C_LOAD, {5'd5, 5'd5, 5'd0}, STL,  2, 2, 0);
        cyc("ld_held",   C_LOAD, {5'd5, 5'd5, 5'd0}, IDLE, 2, 2, 1);
        cyc("ld_after",  C_IDLE, 15'd0,              IDLE, 2, 2, 1);
        cyc("rt_zero_a", C_LOAD, {5'd0, 5'd0, 5'd0}, IDLE, 2, 2, 1);
        cyc("rt_zero_b", C_LOAD, {5'd0, 5'd0, 5'd0}, IDLE, 2, 2, 1);
        cyc("ld_rtid",   C_LOAD, {5'd7, 5'd3, 5'd7}, STL,  2, 2, 1);
        cyc("ld_rtid_h", C_LOAD, {5'd7, 5'd3, 5'd7}, IDLE, 2, 2, 2);

        // Taken and hazard together: taken wins.
        cyc("simul",     C_BOTH, {5'd5, 5'd5, 5'd0}, TKN,  2, 2, 2);
        cyc("simul_sh1", C_BOTH, {5'd5, 5'd5, 5'd0}, IDLE, 3, 3, 2);
        cyc("simul_sh2", C_BOTH, {5'd5, 5'd5, 5'd0}, IDLE, 3, 3, 2);
        cyc("simul_run", C_IDLE, 15'd0,              IDLE, 3, 3, 2);

        // Taken arriving during LDSTALL is honoured.
        cyc("ld2",       C_LOAD, {5'd5, 5'd5, 5'd0}, STL,  3, 3, 2);
        cyc("ld2_taken", C_BOTH, {5'd5, 5'd5, 5'd0}, TKN,  3, 3, 3);
        cyc("ld2_fl1",   C_IDLE, 15'd0,              IDLE, 4, 4, 3);
        cyc("ld2_fl2",   C_IDLE, 15'd0,              IDLE, 4, 4, 3);

        // Asynchronous reset during the second FLUSH cycle.
        cyc("rst_taken", C_TAKEN, 15'd0, TKN,  4, 4, 3);
        cyc("rst_fl1",   C_IDLE,  15'd0, IDLE, 5, 5, 3);
        cyc("rst_pulse", C_RST,   15'd0, ZRO,  0, 0, 0);
        cyc("rst_rel",   C_TAKEN, 15'd0, TKN,  0, 0, 0);
        cyc("rst_fl_a",  C_IDLE,  15'd0, IDLE, 1, 1, 0);
        cyc("rst_fl_b",  C_IDLE,  15'd0, IDLE, 1, 1, 0);

        // Saturation: 20 taken branches spaced past the shadow.
        for (int i = 0; i < 20; i++) begin
            cyc("sat_taken", C_TAKEN, 15'd0, TKN,  1 + i, 1 + i, 0);
            cyc("sat_fl1",   C_IDLE,  15'd0, IDLE, 2 + i, 2 + i, 0);
            cyc("sat_fl2",   C_IDLE,  15'd0, IDLE, 2 + i, 2 + i, 0);
        end
        cyc("sat_final", C_IDLE, 15'd0, IDLE, 21, 21, 0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
